// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset datapath: one shared req/ack memory port, internal control FSM.
// Optional feature macro: MC_BNE_EN enables opcode 0x05 (bne); without it bne traps.
module multicycle_datapath #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out,
  output logic [31:0]       alu_result,
  output logic              instr_retired,
  output logic              trap,
  input  logic [4:0]        dbg_ra,
  output logic [31:0]       dbg_rd
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'h05;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d, alu_q, alu_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d;
  logic [31:0]       regs_q [32];

  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              retire_c, req_c, we_c;
  logic [ADDR_W-1:0] addr_c;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [31:0]       imm_sext, pc_ext, eff_addr;
  logic signed [31:0] a_s, b_s;
  logic [27:0]       j_low;
  logic [ADDR_W-1:0] j_tgt;
  logic              unused_shamt;

  assign opcode       = ir_q[31:26];
  assign rs           = ir_q[25:21];
  assign rt           = ir_q[20:16];
  assign rd           = ir_q[15:11];
  assign funct        = ir_q[5:0];
  assign unused_shamt = ^ir_q[10:6];
  assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign pc_ext       = 32'(pc_q);
  assign eff_addr     = a_q + imm_sext;
  assign a_s          = a_q;
  assign b_s          = b_q;
  assign j_low        = {ir_q[25:0], 2'b00};

  // Jump keeps the PC's upper bits only when the address is wider than the 28-bit target
  generate
    if (ADDR_W > 28) begin : g_jwide
      assign j_tgt = {pc_q[ADDR_W-1:28], j_low};
    end else begin : g_jnarrow
      assign j_tgt = j_low[ADDR_W-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    a_d      = a_q;
    b_d      = b_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    retire_c = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    addr_c   = pc_q;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_W'(3'd4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = regs_q[rs];
        b_d   = regs_q[rt];
        alu_d = pc_ext + (imm_sext << 2);
        case (opcode)
`ifdef MC_BNE_EN
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE: state_d = S_EXEC;
`else
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
`endif
          OP_J: begin
            pc_d     = j_tgt;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (opcode)
          OP_R: begin
            state_d = S_WB;
            case (funct)
              6'h20:   alu_d = a_q + b_q;
              6'h22:   alu_d = a_q - b_q;
              6'h24:   alu_d = a_q & b_q;
              6'h25:   alu_d = a_q | b_q;
              6'h2A:   alu_d = (a_s < b_s) ? 32'd1 : 32'd0;
              default: state_d = S_TRAP;
            endcase
          end
          OP_ADDI: begin
            alu_d   = eff_addr;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = eff_addr;
            state_d = (eff_addr[1:0] != 2'b00) ? S_TRAP : S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = alu_q[ADDR_W-1:0];
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
`ifdef MC_BNE_EN
          OP_BNE: begin
            if (a_q != b_q) pc_d = alu_q[ADDR_W-1:0];
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
`endif
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        we_c   = (opcode == OP_SW);
        addr_c = alu_q[ADDR_W-1:0];
        if (mem_ack) begin
          if (opcode == OP_SW) begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_waddr = (opcode == OP_R) ? rd : rt;
        rf_wdata = (opcode == OP_LW) ? mdr_q : alu_q;
        rf_we    = (rf_waddr != 5'd0);
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  // Request and retire are gated by rst_n so an in-flight access is dropped immediately
  assign mem_req       = req_c & rst_n;
  assign mem_we        = we_c;
  assign mem_addr      = addr_c;
  assign mem_wdata     = b_q;
  assign pc_out        = pc_q;
  assign instr_out     = ir_q;
  assign alu_result    = alu_q;
  assign instr_retired = retire_c & rst_n;
  assign trap          = (state_q == S_TRAP);
  assign dbg_rd        = (dbg_ra == 5'd0) ? 32'd0 : regs_q[dbg_ra];

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
- Parametrised multicycle successor to the single-cycle datapath: one shared memory port with a variable-latency req/ack handshake, replacing the separate instruction and data memories.
- Contains its own control FSM, so there is no external control unit.
- Executes a MIPS subset over several cycles per instruction.
- Reports traps, retirement, and register-file debug reads to the testbench and top level.

Parameters:
- ADDR_W, 32, PC and memory address width (≥8); PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value after reset; must be word-aligned.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- mem_req  out  1  memory request; held until ack
- mem_we  out  1  1=write (sw), 0=read
- mem_addr  out  ADDR_W  byte address, word-aligned
- mem_wdata  out  32  store data
- mem_rdata  in  32  read data, valid when mem_ack=1
- mem_ack  in  1  transfer completes this cycle
- pc_out  out  ADDR_W  current PC
- instr_out  out  32  instruction register
- alu_result  out  32  ALUOut register
- instr_retired  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky; illegal or misaligned instruction
- dbg_ra  in  5  debug register read address
- dbg_rd  out  32  register[dbg_ra], combinational; 0 when dbg_ra=0

Behaviour:
- Reset (sync, active-low): on a clk edge with rst_n=0:
  - state=FETCH, pc=RESET_PC, IR/ALUOut/MDR/A/B=0.
  - All 32 registers cleared; trap=0, instr_retired=0.
  - mem_req is forced 0 while rst_n=0.
  - Reset mid-transaction abandons the access; memory must tolerate the dropped request.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable from request assertion until the cycle mem_ack=1.
  - Ack may arrive in the first request cycle (zero-wait).
  - mem_ack while mem_req=0 is ignored.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH: request read at pc. On ack: IR<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE: A<=reg[rs], B<=reg[rt], ALUOut<=pc+(sext(imm)<<2). Dispatch by opcode:
  - 0x00 R-type, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq: go to EXEC.
  - 0x02 j: pc<={pc[ADDR_W-1:28], target26, 2'b00} (truncated when ADDR_W<28); retire; go to FETCH.
  - Any other opcode: go to TRAP.
- EXEC:
  - R-type: funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed). Result to ALUOut; go to WB. Other funct values go to TRAP.
  - addi: ALUOut<=A+sext(imm); go to WB.
  - lw/sw: ALUOut<=A+sext(imm). If the address has bits[1:0]≠0, go to TRAP with no request issued; otherwise go to MEM.
  - beq: if A==B, pc<=ALUOut. Retire; go to FETCH.
- MEM: address=ALUOut[ADDR_W-1:0].
  - sw: write B. On ack, retire and go to FETCH.
  - lw: read. On ack, MDR<=mem_rdata and go to WB.
- WB:
  - Destination is rd for R-type, rt for addi/lw.
  - Data is MDR for lw, ALUOut otherwise.
  - Writes to register 0 are discarded.
  - Retire; go to FETCH.
- TRAP: trap=1 and mem_req=0; the block stays here until reset. The trapping instruction does not retire.
- Arithmetic: 32-bit, overflow ignored (addi/add wrap).
- Latency (zero-wait memory), counted from the FETCH cycle to the retire pulse inclusive:
  - j: 2; beq: 3; R-type, addi, sw: 4; lw: 5.
  - Each wait cycle adds 1 per memory access.
- instr_retired is asserted for exactly one cycle, on the transition back to FETCH.

Optional Feature:
- MC_BNE_EN defined: opcode 0x05 (bne) is legal. It is handled like beq but taken when A≠B, with latency 3.
- MC_BNE_EN undefined: opcode 0x05 traps.

Test Plan:
- Reset: RESET_PC=0x100, rst_n low for 2 cycles then released -> pc_out=0x100, trap=0. Next cycle: mem_req=1, mem_we=0, mem_addr=0x100.
- Arithmetic: addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; slt $4,$2,$1; sub $5,$0,$1, zero-wait memory -> dbg_rd($3)=12, $4=0, $5=0xFFFFFFFB. Five retire pulses, 4 cycles apart.
- Memory with waits: sw $3,0x40($0), then lw $6,0x40($0), with ack delayed 3 cycles on every access ->
  - Store request: mem_we=1, addr=0x40, wdata=12, held stable through the waits.
  - dbg_rd($6)=12.
  - lw retires 11 cycles after its fetch begins.
- Branches: at pc 0x10, beq $1,$1,+2 -> next fetch at 0x1C. beq $1,$2,+2 -> next fetch at 0x14. j 0x40 -> fetch at 0x100.
- Traps:
  - Opcode 0x3F -> trap=1, mem_req stays 0 for 20+ cycles, no retire pulse.
  - lw $1,2($0) -> trap with no memory request.
  - Reset clears trap.
- Optional feature: bne $1,$2,+1 where $1≠$2, at pc 0x20 -> with MC_BNE_EN, next fetch at 0x28; without it, trap=1.
